// File: rtl/cache_metadata_assoc.sv
// ---------------------------------------------------------------------------
// cache_metadata_assoc
//   Tag/valid/dirty/LRU metadata for a set-associative cache, plus a flush
//   walker that visits every entry and offers dirty lines for writeback.
//
// Ports
//   clk, reset_n           : clock, asynchronous active-low reset
//   set, tag               : access address (set index, tag)
//   lookup                 : access strobe; a hit makes the hit way MRU
//   install                : write tag into victim_way (valid=1, dirty=0)
//   invalidate_sel         : clear valid of the hit way (beats install)
//   set_dirty_sel          : mark the hit way dirty
//   clear_dirty_sel        : mark the hit way clean (beats set_dirty_sel)
//   hit, hit_way           : lookup result (combinational)
//   victim_way             : replacement choice for set (combinational)
//   victim_valid_dirty     : victim entry needs writeback before reuse
//   victim_tag             : tag currently held by the victim entry
//   flush_req              : start a walk over all entries
//   flush_invalidate       : captured with flush_req; walk clears valid bits
//   flush_busy             : walker active, access port ignored
//   flush_valid/flush_ready: writeback offer handshake
//   flush_set/way/tag      : offered entry (zero when nothing is offered)
//   flush_done             : one-cycle pulse at end of walk
// ---------------------------------------------------------------------------
module cache_metadata_assoc #(
    parameter int NUM_SETS  = 4,
    parameter int SET_SIZE  = 2,
    parameter int TAG_SIZE  = 30,
    parameter int NUM_WAYS  = 2,
    parameter int WAY_SIZE  = 1,
    parameter int READ_ONLY = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SET_SIZE-1:0] set,
    input  logic [TAG_SIZE-1:0] tag,
    input  logic                lookup,
    input  logic                install,
    input  logic                invalidate_sel,
    input  logic                set_dirty_sel,
    input  logic                clear_dirty_sel,
    output logic                hit,
    output logic [WAY_SIZE-1:0] hit_way,
    output logic [WAY_SIZE-1:0] victim_way,
    output logic                victim_valid_dirty,
    output logic [TAG_SIZE-1:0] victim_tag,
    input  logic                flush_req,
    input  logic                flush_invalidate,
    output logic                flush_busy,
    output logic                flush_valid,
    input  logic                flush_ready,
    output logic [SET_SIZE-1:0] flush_set,
    output logic [WAY_SIZE-1:0] flush_way,
    output logic [TAG_SIZE-1:0] flush_tag,
    output logic                flush_done
);

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} flush_state_e;

    logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_SIZE-1:0] age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

    flush_state_e        state_q, state_d;
    logic [SET_SIZE-1:0] idx_set_q;
    logic [WAY_SIZE-1:0] idx_way_q;
    logic                flush_inv_q;

    logic [NUM_WAYS-1:0] match;
    logic                victim_found;
    logic                entry_vd, idx_last, advance, fl_accept;
    logic                do_inval, do_install, do_touch, do_set_dirty, do_clear_dirty;
    logic [WAY_SIZE-1:0] touch_way;

    // ---------------- lookup / victim selection ----------------
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        match = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            match[w] = valid_q[set][w] && (tag_q[set][w] == tag);
    end

    // The access port is blind while the walker owns the array.
    assign hit = (|match) && !flush_busy;

    always_comb begin
        hit_way = '0;
        if (hit)
            for (int w = 0; w < NUM_WAYS; w++)
                if (match[w]) hit_way = WAY_SIZE'(w);
    end

    // Prefer the lowest free way; only evict the LRU way when the set is full.
    always_comb begin
        victim_way   = '0;
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!valid_q[set][w] && !victim_found) begin
                victim_way   = WAY_SIZE'(w);
                victim_found = 1'b1;
            end
        if (!victim_found)
            for (int w = 0; w < NUM_WAYS; w++)
                if (age_q[set][w] == WAY_SIZE'(NUM_WAYS - 1)) victim_way = WAY_SIZE'(w);
    end

    assign victim_valid_dirty = valid_q[set][victim_way] & dirty_q[set][victim_way];
    assign victim_tag         = tag_q[set][victim_way];

    // ---------------- access-side update enables ----------------
    assign do_inval       = invalidate_sel & hit;
    assign do_install     = install & !flush_busy & !do_inval;
    assign do_touch       = do_install | (lookup & hit);
    assign touch_way      = do_install ? victim_way : hit_way;
    assign do_set_dirty   = set_dirty_sel & hit & !clear_dirty_sel;
    assign do_clear_dirty = clear_dirty_sel & hit;

    // ---------------- flush walker ----------------
    assign entry_vd  = valid_q[idx_set_q][idx_way_q] & dirty_q[idx_set_q][idx_way_q];
    assign idx_last  = (idx_set_q == SET_SIZE'(NUM_SETS - 1)) && (idx_way_q == WAY_SIZE'(NUM_WAYS - 1));
    assign fl_accept = (state_q == OFFER) && flush_ready;

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE:  if (flush_req) state_d = SCAN;
            SCAN:  if (entry_vd) state_d = OFFER; else advance = 1'b1;
            OFFER: if (flush_ready) advance = 1'b1;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (advance) state_d = idx_last ? DONE : SCAN;
    end

    assign flush_busy  = (state_q != IDLE);
    assign flush_valid = (READ_ONLY == 0) && (state_q == OFFER);
    assign flush_done  = (state_q == DONE);
    assign flush_set   = flush_valid ? idx_set_q : '0;
    assign flush_way   = flush_valid ? idx_way_q : '0;
    assign flush_tag   = flush_valid ? tag_q[idx_set_q][idx_way_q] : '0;

    // ---------------- state: FSM, index, valid, LRU ages ----------------
    // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_set_q   <= '0;
            idx_way_q   <= '0;
            flush_inv_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_SIZE'(w);
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && flush_req) begin
                idx_set_q   <= '0;
                idx_way_q   <= '0;
                flush_inv_q <= flush_invalidate;
            end else if (advance) begin
                // Way-first order; the set index wraps to 0 after the last entry.
                if (idx_way_q == WAY_SIZE'(NUM_WAYS - 1)) begin
                    idx_way_q <= '0;
                    idx_set_q <= idx_set_q + SET_SIZE'(1);
                end else begin
                    idx_way_q <= idx_way_q + WAY_SIZE'(1);
                end
            end

            if (do_inval)   valid_q[set][hit_way]    <= 1'b0;
            if (do_install) valid_q[set][victim_way] <= 1'b1;
            if (advance && flush_inv_q) valid_q[idx_set_q][idx_way_q] <= 1'b0;

            // Ages younger than the touched way grow by one; the touched way becomes MRU.
            if (do_touch) begin
                for (int v = 0; v < NUM_WAYS; v++)
                    if (age_q[set][v] < age_q[set][touch_way])
                        age_q[set][v] <= age_q[set][v] + WAY_SIZE'(1);
                age_q[set][touch_way] <= '0;
            end
        end
    end

    // NOTE: the tag array has no reset; valid bits qualify every tag, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_install) tag_q[set][victim_way] <= tag;
    end

    // ---------------- dirty bits ----------------
    generate
        if (READ_ONLY != 0) begin : g_no_dirty
            always_comb
                for (int s = 0; s < NUM_SETS; s++) dirty_q[s] = '0;
        end else begin : g_dirty
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < NUM_SETS; s++) dirty_q[s] <= '0;
                end else begin
                    if (do_set_dirty)   dirty_q[set][hit_way]    <= 1'b1;
                    if (do_clear_dirty) dirty_q[set][hit_way]    <= 1'b0;
                    if (do_install)     dirty_q[set][victim_way] <= 1'b0;
                    if (fl_accept)      dirty_q[idx_set_q][idx_way_q] <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cache_metadata_assoc.sv
// ---------------------------------------------------------------------------
// tb_cache_metadata_assoc
//   Directed bench: a default instance (dut) and a READ_ONLY instance (dut_ro).
//   Inputs change 1 time unit after the rising edge; outputs are compared a
//   further time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_cache_metadata_assoc;

    localparam logic [29:0] TAG_A = 30'h0AAA_0001;
    localparam logic [29:0] TAG_B = 30'h0BBB_0002;
    localparam logic [29:0] TAG_C = 30'h0CCC_0003;
    localparam logic [29:0] TAG_E = 30'h0EEE_0005;
    localparam logic [29:0] TAG_F = 30'h0FFF_0006;
    localparam logic [29:0] TAG_G = 30'h1111_0007;
    localparam logic [29:0] TAG_H = 30'h2222_0008;
    localparam logic [29:0] TAG_J = 30'h3333_0009;
    localparam logic [29:0] TAG_K = 30'h0444_000A;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // default instance signals
    logic [1:0]  set_sel = '0;
    logic [29:0] tag_val = '0;
    logic lookup = 0, install = 0, inval = 0, sd = 0, cd = 0;
    logic flush_req = 0, flush_inv = 0, flush_ready = 0;
    logic hit, victim_vd, flush_busy, flush_valid, flush_done;
    logic [0:0]  hit_way, victim_way, flush_way;
    logic [29:0] victim_tag, flush_tag;
    logic [1:0]  flush_set;

    // READ_ONLY instance signals
    logic [1:0]  ro_set = '0;
    logic [29:0] ro_tag = '0;
    logic ro_lookup = 0, ro_install = 0, ro_inval = 0, ro_sd = 0, ro_cd = 0;
    logic ro_flush_req = 0, ro_flush_inv = 0, ro_flush_ready = 0;
    logic ro_hit, ro_victim_vd, ro_busy, ro_fvalid, ro_done;
    logic [0:0]  ro_hit_way, ro_victim_way, ro_fway;
    logic [29:0] ro_victim_tag, ro_ftag;
    logic [1:0]  ro_fset;

    int n_cmp = 0;
    int n_err = 0;

    cache_metadata_assoc dut (
        .clk(clk), .reset_n(reset_n), .set(set_sel), .tag(tag_val),
        .lookup(lookup), .install(install), .invalidate_sel(inval),
        .set_dirty_sel(sd), .clear_dirty_sel(cd),
        .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
        .victim_valid_dirty(victim_vd), .victim_tag(victim_tag),
        .flush_req(flush_req), .flush_invalidate(flush_inv),
        .flush_busy(flush_busy), .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_set(flush_set), .flush_way(flush_way), .flush_tag(flush_tag),
        .flush_done(flush_done)
    );

    cache_metadata_assoc #(.READ_ONLY(1)) dut_ro (
        .clk(clk), .reset_n(reset_n), .set(ro_set), .tag(ro_tag),
        .lookup(ro_lookup), .install(ro_install), .invalidate_sel(ro_inval),
        .set_dirty_sel(ro_sd), .clear_dirty_sel(ro_cd),
        .hit(ro_hit), .hit_way(ro_hit_way), .victim_way(ro_victim_way),
        .victim_valid_dirty(ro_victim_vd), .victim_tag(ro_victim_tag),
        .flush_req(ro_flush_req), .flush_invalidate(ro_flush_inv),
        .flush_busy(ro_busy), .flush_valid(ro_fvalid), .flush_ready(ro_flush_ready),
        .flush_set(ro_fset), .flush_way(ro_fway), .flush_tag(ro_ftag),
        .flush_done(ro_done)
    );

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_install(input logic [1:0] s, input logic [29:0] t);
        set_sel = s; tag_val = t; install = 1'b1;
        tick();
        install = 1'b0;
    endtask

    task automatic probe(input string nm, input logic [1:0] s, input logic [29:0] t,
                         input logic exp_hit, input logic exp_way);
        set_sel = s; tag_val = t;
        #1;
        check({nm, "_hit"}, hit, exp_hit);
        check({nm, "_way"}, hit_way, exp_way);
    endtask

    task automatic strobe_dirty(input logic [1:0] s, input logic [29:0] t,
                                input logic set_d, input logic clr_d);
        set_sel = s; tag_val = t; sd = set_d; cd = clr_d;
        tick();
        sd = 1'b0; cd = 1'b0;
    endtask

    initial begin
        int cyc, done_cyc, offers, ocnt, fv_seen;
        logic [1:0]  exp_s [2];
        logic [0:0]  exp_w [2];
        logic [29:0] exp_t [2];

        // ---------------- reset state ----------------
        #2;
        check("rst_busy", flush_busy, 0);
        check("rst_fvalid", flush_valid, 0);
        check("rst_done", flush_done, 0);
        check("rst_hit", hit, 0);
        check("rst_vvd", victim_vd, 0);
        check("rst_victim", victim_way, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // ---------------- install two tags, lookup ----------------
        set_sel = 2'd1; #1;
        check("s1_victim_empty", victim_way, 0);
        do_install(2'd1, TAG_A);
        #1 check("s1_victim_after_A", victim_way, 1);
        do_install(2'd1, TAG_B);
        probe("lookup_A", 2'd1, TAG_A, 1, 0);
        lookup = 1'b1; tick(); lookup = 1'b0;
        #1 check("victim_after_lookup_A", victim_way, 1);

        // ---------------- LRU replacement ----------------
        probe("lookup_B", 2'd1, TAG_B, 1, 1);
        lookup = 1'b1; tick(); lookup = 1'b0;
        #1 check("victim_after_lookup_B", victim_way, 0);
        do_install(2'd1, TAG_C);
        probe("A_evicted", 2'd1, TAG_A, 0, 0);
        probe("C_in_way0", 2'd1, TAG_C, 1, 0);
        probe("B_kept", 2'd1, TAG_B, 1, 1);

        // ---------------- invalidate beats install ----------------
        do_install(2'd2, TAG_A);
        probe("s2_A_pre", 2'd2, TAG_A, 1, 0);
        inval = 1'b1; install = 1'b1;
        tick();
        inval = 1'b0; install = 1'b0;
        probe("s2_A_gone", 2'd2, TAG_A, 0, 0);
        check("s2_victim_free", victim_way, 0);

        // ---------------- dirty strobes ----------------
        do_install(2'd2, TAG_E);
        do_install(2'd2, TAG_F);
        strobe_dirty(2'd2, TAG_E, 1, 0);
        #1;
        check("s2_victim_E", victim_way, 0);
        check("s2_victim_tag", victim_tag, TAG_E);
        check("s2_vvd_set", victim_vd, 1);
        strobe_dirty(2'd2, TAG_E, 1, 1);
        #1 check("s2_vvd_clear_wins", victim_vd, 0);

        // ---------------- flush with offers and invalidate ----------------
        do_install(2'd0, TAG_G);
        do_install(2'd0, TAG_H);
        strobe_dirty(2'd0, TAG_H, 1, 0);
        do_install(2'd3, TAG_J);
        strobe_dirty(2'd3, TAG_J, 1, 0);
        exp_s[0] = 2'd0; exp_w[0] = 1'b1; exp_t[0] = TAG_H;
        exp_s[1] = 2'd3; exp_w[1] = 1'b0; exp_t[1] = TAG_J;

        flush_req = 1'b1; flush_inv = 1'b1;
        tick();
        flush_req = 1'b0; flush_inv = 1'b0;
        cyc = 1; done_cyc = 0; offers = 0; ocnt = 0;
        while (done_cyc == 0 && cyc < 60) begin
            if (cyc == 1) begin
                set_sel = 2'd1; tag_val = TAG_C; #1;
                check("busy_during_walk", flush_busy, 1);
                check("hit_masked_busy", hit, 0);
            end
            if (flush_valid) begin
                if (offers < 2) begin
                    check("offer_set", flush_set, exp_s[offers]);
                    check("offer_way", flush_way, exp_w[offers]);
                    check("offer_tag", flush_tag, exp_t[offers]);
                end else begin
                    check("extra_offer", flush_valid, 0);
                end
                ocnt++;
                flush_ready = (ocnt == 4);
                if (ocnt == 4) begin
                    offers++;
                    ocnt = 0;
                end
            end else begin
                flush_ready = 1'b0;
            end
            if (flush_done) done_cyc = cyc;
            tick();
            cyc++;
        end
        flush_ready = 1'b0;
        check("flush_done_cycle", done_cyc, 17);
        check("offer_count", offers, 2);
        check("done_one_pulse", flush_done, 0);
        check("busy_after_walk", flush_busy, 0);
        probe("post_G", 2'd0, TAG_G, 0, 0);
        probe("post_H", 2'd0, TAG_H, 0, 0);
        probe("post_C", 2'd1, TAG_C, 0, 0);
        probe("post_B", 2'd1, TAG_B, 0, 0);
        probe("post_F", 2'd2, TAG_F, 0, 0);
        probe("post_J", 2'd3, TAG_J, 0, 0);

        // ---------------- READ_ONLY: clean flush ----------------
        ro_set = 2'd0; ro_tag = TAG_K; ro_install = 1'b1;
        tick();
        ro_install = 1'b0; ro_sd = 1'b1;
        tick();
        ro_sd = 1'b0;
        ro_flush_req = 1'b1; ro_flush_ready = 1'b1;
        tick();
        ro_flush_req = 1'b0;
        cyc = 1; done_cyc = 0; fv_seen = 0;
        while (done_cyc == 0 && cyc < 40) begin
            if (ro_fvalid) fv_seen++;
            if (ro_done) done_cyc = cyc;
            tick();
            cyc++;
        end
        ro_flush_ready = 1'b0;
        check("ro_done_cycle", done_cyc, 9);
        check("ro_no_offer", fv_seen, 0);
        #1 check("ro_K_kept", ro_hit, 1);

        // ---------------- READ_ONLY: reset mid-walk ----------------
        ro_flush_req = 1'b1;
        tick();
        ro_flush_req = 1'b0;
        tick();
        tick();
        check("ro_busy_mid", ro_busy, 1);
        reset_n = 1'b0;
        #1;
        check("ro_busy_reset", ro_busy, 0);
        check("ro_done_reset", ro_done, 0);
        check("ro_hit_reset", ro_hit, 0);
        check("dut_victim_reset", victim_way, 0);
        fv_seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) reset_n = 1'b1;
            if (ro_done) fv_seen++;
            tick();
        end
        check("ro_no_done_after_abort", fv_seen, 0);
        check("ro_idle_after_abort", ro_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
